// File: rtl/uart_irq_ctrl_if.sv
// UART interrupt-controller register-side bus: source events, IER enables, IRQ/IIR results.
// Pure signal bundle, no storage and no added latency.
// No backpressure: every strobe is a single-cycle event consumed by the controller.
interface uart_irq_ctrl_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [3:0]    ier;
  logic          baud_out;
  logic [LW-1:0] rx_level;
  logic [LW-1:0] rx_trig_level;
  logic          rx_push;
  logic          rbr_rd;
  logic          ls_err;
  logic          lsr_rd;
  logic          thr_empty;
  logic          thr_wr;
  logic          msr_delta;
  logic          msr_rd;
  logic          iir_rd;
  logic          IRQ;
  logic [3:0]    iir;

  // Register file / UART datapath side: drives events, observes the interrupt result.
  modport master (
    output ier, baud_out, rx_level, rx_trig_level, rx_push, rbr_rd,
           ls_err, lsr_rd, thr_empty, thr_wr, msr_delta, msr_rd, iir_rd,
    input  IRQ, iir
  );

  // Interrupt controller side.
  modport slave (
    input  ier, baud_out, rx_level, rx_trig_level, rx_push, rbr_rd,
           ls_err, lsr_rd, thr_empty, thr_wr, msr_delta, msr_rd, iir_rd,
    output IRQ, iir
  );
endinterface

// File: rtl/uart_irq_ctrl.sv
// 16550-style interrupt controller: pending flags, IER masking, fixed priority, IRQ/IIR.
// IRQ and iir are registered and reflect a source event exactly one CLK later.
// No backpressure: strobes are consumed the cycle they arrive; set beats clear on collision.
module uart_irq_ctrl #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input logic           CLK,
  input logic           RST,
  uart_irq_ctrl_if.slave bus
);
  localparam int              CW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0]   T_MAX    = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0]   T_LAST   = CW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]      IIR_NONE = 4'b0001;
  localparam logic [3:0]      IIR_RLS  = 4'b0110;
  localparam logic [3:0]      IIR_RDA  = 4'b0100;
  localparam logic [3:0]      IIR_CTI  = 4'b1100;
  localparam logic [3:0]      IIR_THRE = 4'b0010;
  localparam logic [3:0]      IIR_MS   = 4'b0000;

  logic          rls_q, cti_q, thre_q, ms_q;
  logic          thr_empty_q, ier1_q, irq_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    iir_q;

  logic          rls_d, rda_d, cti_d, thre_d, ms_d, irq_d;
  logic          cnt_zero, cti_set, thre_set, thre_clr;
  logic [CW-1:0] cnt_d;
  logic [3:0]    iir_d;

  // Next-state of every source plus priority encode of the enabled ones.
  // IRQ/iir are computed from the next flag values so they land one cycle after the event.
  always_comb begin
    cnt_zero = bus.rx_push | bus.rbr_rd | (bus.rx_level == '0);
    cnt_d    = cnt_q;
    if (cnt_zero)
      cnt_d = '0;
    else if (bus.baud_out && cnt_q != T_MAX)
      cnt_d = cnt_q + CW'(1);

    // Only the tick that carries the counter onto the limit fires; a saturated
    // counter does not re-arm a cleared timeout.
    cti_set = !cnt_zero && bus.baud_out && (cnt_q == T_LAST);

    rls_d = bus.ls_err | (rls_q & ~bus.lsr_rd);
    rda_d = (bus.rx_level >= bus.rx_trig_level);
    cti_d = cti_set | (cti_q & ~(bus.rbr_rd | bus.rx_push));

    thre_set = (bus.thr_empty & ~thr_empty_q) | (bus.ier[1] & ~ier1_q & bus.thr_empty);
    thre_clr = bus.thr_wr | (bus.iir_rd && iir_q == IIR_THRE);
    thre_d   = thre_set | (thre_q & ~thre_clr);

    ms_d = bus.msr_delta | (ms_q & ~bus.msr_rd);

    iir_d = IIR_NONE;
    irq_d = 1'b1;
    if (bus.ier[2] && rls_d)
      iir_d = IIR_RLS;
    else if (bus.ier[0] && rda_d)
      iir_d = IIR_RDA;
    else if (bus.ier[0] && cti_d)
      iir_d = IIR_CTI;
    else if (bus.ier[1] && thre_d)
      iir_d = IIR_THRE;
    else if (bus.ier[3] && ms_d)
      iir_d = IIR_MS;
    else
      irq_d = 1'b0;
  end

  // State register; reset overrides every set condition in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rls_q       <= 1'b0;
      cti_q       <= 1'b0;
      thre_q      <= 1'b0;
      ms_q        <= 1'b0;
      cnt_q       <= '0;
      thr_empty_q <= 1'b1;
      ier1_q      <= 1'b0;
      irq_q       <= 1'b0;
      iir_q       <= IIR_NONE;
    end else begin
      rls_q       <= rls_d;
      cti_q       <= cti_d;
      thre_q      <= thre_d;
      ms_q        <= ms_d;
      cnt_q       <= cnt_d;
      thr_empty_q <= bus.thr_empty;
      ier1_q      <= bus.ier[1];
      irq_q       <= irq_d;
      iir_q       <= iir_d;
    end
  end

  assign bus.IRQ = irq_q;
  assign bus.iir = iir_q;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed bench for uart_irq_ctrl with hand-computed IRQ/iir expectations.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
// No backpressure on this block; every wait is a fixed cycle count.
module tb_uart_irq_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  uart_irq_ctrl_if #(.FIFO_DEPTH(16)) bus ();

  uart_irq_ctrl #(.FIFO_DEPTH(16), .TIMEOUT_TICKS(640)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic irq_e, input logic [3:0] iir_e);
    chk({tag, ".irq"}, {3'b000, bus.IRQ}, {3'b000, irq_e});
    chk({tag, ".iir"}, bus.iir, iir_e);
  endtask

  initial begin
    bus.ier = 4'hF; bus.baud_out = 0; bus.rx_level = 0; bus.rx_trig_level = 4;
    bus.rx_push = 0; bus.rbr_rd = 0; bus.ls_err = 1; bus.lsr_rd = 0;
    bus.thr_empty = 0; bus.thr_wr = 0; bus.msr_delta = 1; bus.msr_rd = 0; bus.iir_rd = 0;

    // Reset held two cycles with sources pulsing
    RST = 1;
    tick(); chk_out("rst0", 1'b0, 4'b0001);
    tick(); chk_out("rst1", 1'b0, 4'b0001);
    RST = 0; bus.ls_err = 0; bus.msr_delta = 0;
    tick(); chk_out("rst_rel", 1'b0, 4'b0001);

    // Priority walk
    bus.rx_level = 8; bus.rx_trig_level = 4; bus.ls_err = 1; bus.msr_delta = 1;
    tick(); bus.ls_err = 0; bus.msr_delta = 0;
    chk_out("pri_rls", 1'b1, 4'b0110);
    bus.lsr_rd = 1; tick(); bus.lsr_rd = 0;
    chk_out("pri_rda", 1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      bus.rbr_rd = 1; bus.rx_level = bus.rx_level - 1; tick();
    end
    bus.rbr_rd = 0;
    chk_out("pri_ms", 1'b1, 4'b0000);
    bus.msr_rd = 1; tick(); bus.msr_rd = 0;
    chk_out("pri_none", 1'b0, 4'b0001);

    // Character timeout
    bus.ier = 4'h1; bus.rx_level = 0; bus.rx_trig_level = 8;
    tick();
    bus.rx_level = 2;
    tick();
    for (int i = 0; i < 639; i++) begin
      bus.baud_out = 1; tick(); bus.baud_out = 0; tick();
    end
    chk_out("cti_639", 1'b0, 4'b0001);
    bus.baud_out = 1; tick(); bus.baud_out = 0;
    chk_out("cti_640", 1'b1, 4'b1100);
    tick(); chk_out("cti_hold", 1'b1, 4'b1100);
    bus.rbr_rd = 1; tick(); bus.rbr_rd = 0;
    chk_out("cti_clr", 1'b0, 4'b0001);
    bus.rx_level = 0;
    tick();

    // THRE set/clear paths
    bus.ier = 4'h2; bus.thr_empty = 1;
    tick(); chk_out("thre_edge", 1'b1, 4'b0010);
    bus.iir_rd = 1; tick(); bus.iir_rd = 0;
    chk_out("thre_iirrd", 1'b0, 4'b0001);
    bus.ier = 4'h0; tick();
    bus.ier = 4'h2; tick();
    chk_out("thre_ier", 1'b1, 4'b0010);
    bus.thr_wr = 1; tick(); bus.thr_wr = 0;
    chk_out("thre_wr", 1'b0, 4'b0001);
    bus.thr_empty = 0; tick();

    // Masking keeps the flag pending
    bus.ier = 4'h0; bus.msr_delta = 1; tick(); bus.msr_delta = 0;
    chk_out("mask_off", 1'b0, 4'b0001);
    tick(); chk_out("mask_hold", 1'b0, 4'b0001);
    bus.ier = 4'h8; tick();
    chk_out("mask_on", 1'b1, 4'b0000);

    // Reset mid-operation clears the pending MS flag
    RST = 1; tick(); RST = 0;
    chk_out("mid_rst", 1'b0, 4'b0001);
    tick(); chk_out("mid_rst_after", 1'b0, 4'b0001);

    // Set/clear collision on RLS
    bus.ier = 4'h4; bus.ls_err = 1; bus.lsr_rd = 1;
    tick(); bus.ls_err = 0; bus.lsr_rd = 0;
    chk_out("coll_rls", 1'b1, 4'b0110);
    bus.lsr_rd = 1; tick(); bus.lsr_rd = 0;
    chk_out("coll_clr", 1'b0, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/uart_irq_ctrl.md
Name: uart_irq_ctrl

Overview:
Interrupt controller for the 16550-style UART. It tracks the five interrupt sources: receiver line status, RX data available, character timeout, THR empty and modem status. It applies the IER enables, resolves fixed priority, and drives the registered IRQ line and the IIR identification code. Character-timeout timing counts baud_out ticks, the 16x baud enable from the baud generator.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth; sets the width of rx_level.
TIMEOUT_TICKS, 640, baud_out ticks without RX activity before a character timeout (4 chars x 10 bits x 16).

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
ier  in  4  [0] RDA/CTI enable, [1] THRE enable, [2] RLS enable, [3] MS enable
baud_out  in  1  one-CLK 16x baud tick
rx_level  in  $clog2(FIFO_DEPTH+1)  current RX FIFO occupancy
rx_trig_level  in  $clog2(FIFO_DEPTH+1)  RX trigger threshold (1..FIFO_DEPTH)
rx_push  in  1  byte written into RX FIFO this cycle
rbr_rd  in  1  RBR read strobe
ls_err  in  1  pulse: overrun, parity, framing or break detected
lsr_rd  in  1  LSR read strobe
thr_empty  in  1  level: TX FIFO/THR empty
thr_wr  in  1  THR write strobe
msr_delta  in  1  pulse: any modem-status delta bit set
msr_rd  in  1  MSR read strobe
iir_rd  in  1  IIR read strobe
IRQ  out  1  interrupt request, active-high
iir  out  4  interrupt ID: 0001 none, 0110 RLS, 0100 RDA, 1100 CTI, 0010 THRE, 0000 MS

Behaviour:
- Reset: all pending flags 0, timeout counter 0, thr_empty edge register 1, IRQ=0, iir=4'b0001.
- Reset mid-operation clears all pending state on the next edge. No source may re-raise in the cycle RST is high.
- All pending flags, IRQ and iir are registered. iir and IRQ reflect source events exactly 1 CLK after the event.
- rls_p (RLS pending):
  - set on ls_err; cleared on lsr_rd.
  - Set and clear in the same cycle: set wins.
- rda (RX data available) is a level condition, not a latch: rx_level >= rx_trig_level. It clears automatically once reads drop the level below the trigger.
- Timeout counter:
  - Zeroed on rx_push, rbr_rd, or rx_level==0.
  - Otherwise increments on baud_out and saturates at TIMEOUT_TICKS.
  - cti_p sets when the counter reaches TIMEOUT_TICKS with rx_level>0.
  - cti_p clears on rbr_rd or rx_push; re-arms only via a new full timeout.
- thre_p (THR empty pending) sets on:
  - a thr_empty rising edge, or
  - ier[1] rising while thr_empty=1.
- thre_p clears on:
  - thr_wr, or
  - iir_rd in a cycle where registered iir==0010.
  - A set condition in the same cycle as a clear wins.
- ms_p: set on msr_delta; cleared on msr_rd; set wins on collision.
- Priority, highest first: RLS > RDA > CTI > THRE > MS. Only sources whose IER bit is 1 are considered. RDA and CTI share ier[0].
- iir_next = code of the highest enabled active source, else 0001. IRQ_next = any enabled source active.
- Clearing an ier bit masks its source immediately (next cycle) but does not clear the pending flag. Re-enabling re-asserts IRQ if the flag is still pending.
- An iir_rd has no side effect other than the THRE clear above.

Test Plan:
- Reset: RST high 2 cycles with ls_err=1, msr_delta=1 -> IRQ=0, iir=0001 throughout and one cycle after release.
- Priority: ier=4'hF, ls_err and msr_delta pulse together, rx_level=8, trig=4:
  - iir=0110 next cycle;
  - after lsr_rd -> 0100;
  - rbr_rd until rx_level=3 -> 0000;
  - msr_rd -> 0001, IRQ=0.
- Timeout: rx_level=2, trig=8, no activity, 640 baud_out ticks -> iir=1100 on the cycle after the 640th tick (not before tick 640). One rbr_rd then clears it.
- THRE:
  - thr_empty 0->1 with ier=4'h2 -> iir=0010, IRQ=1;
  - iir_rd -> IRQ=0;
  - ier[1] toggled 0->1 while still empty -> IRQ=1 again;
  - thr_wr -> IRQ=0.
- Masking: ms_p pending with ier[3]=0 -> IRQ=0, iir=0001. Set ier[3]=1 -> IRQ=1, iir=0000 next cycle.
- Collision: ls_err and lsr_rd in the same cycle -> rls_p remains set, iir=0110.
